// File: rtl/echo_range_meter.sv
// HC-SR04 ultrasonic range meter: trigger pulse generation, echo width timing in microseconds,
// centimetre conversion by repeated US_PER_CM division, timeout and post-measurement holdoff.
module echo_range_meter #(
  parameter int unsigned CLKS_PER_US = 64,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned TIMEOUT_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 60000,
  parameter int unsigned US_PER_CM   = 58
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_enable,
  input  logic        i_echo,
  output logic        o_trigger,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_timeout,
  output logic [15:0] o_width_us,
  output logic [9:0]  o_dist_cm,
  output logic [2:0]  o_state
);

  localparam int unsigned US_W  = 16;
  localparam int unsigned CM_W  = 10;
  localparam int unsigned PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int unsigned SUB_W = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [US_W-1:0]   us_q, us_d, us_inc;
  logic [SUB_W-1:0]  sub_q, sub_d, sub_inc;
  logic [CM_W-1:0]   cm_q, cm_d, cm_inc;
  logic [PRE_W-1:0]  pre_q;
  logic              pre_clr, tick;
  logic              echo_s1, echo_s2, echo_prev, rise, fall;
  logic              valid_d, timeout_d;
  logic [US_W-1:0]   width_d;
  logic [CM_W-1:0]   dist_d;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      echo_s1   <= 1'b0;
      echo_s2   <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      echo_s1   <= i_echo;
      echo_s2   <= echo_s1;
      echo_prev <= echo_s2;
    end
  end

  assign rise = echo_s2 & ~echo_prev;
  assign fall = ~echo_s2 & echo_prev;

  // Microsecond prescaler; restarted on TRIG and HOLDOFF entry so those phases are exact
  always_ff @(posedge i_clk) begin
    if (i_rst || pre_clr)                          pre_q <= '0;
    else if (pre_q == PRE_W'(CLKS_PER_US - 1))     pre_q <= '0;
    else                                           pre_q <= pre_q + PRE_W'(1);
  end

  assign tick = (pre_q == PRE_W'(CLKS_PER_US - 1));

  // Saturating counter values after this cycle's tick
  always_comb begin
    us_inc  = us_q;
    sub_inc = sub_q;
    cm_inc  = cm_q;
    if (tick) begin
      if (us_q != '1) us_inc = us_q + US_W'(1);
      if (sub_q == SUB_W'(US_PER_CM - 1)) begin
        sub_inc = '0;
        if (cm_q != '1) cm_inc = cm_q + CM_W'(1);
      end else begin
        sub_inc = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      us_q    <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
    end else begin
      state_q <= state_d;
      us_q    <= us_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    us_d      = us_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    pre_clr   = 1'b0;
    valid_d   = 1'b0;
    timeout_d = o_timeout;
    width_d   = o_width_us;
    dist_d    = o_dist_cm;
    case (state_q)
      IDLE: begin
        if (i_start || i_enable) begin
          state_d = TRIG;
          us_d    = '0;
          sub_d   = '0;
          cm_d    = '0;
          pre_clr = 1'b1;
        end
      end
      TRIG: begin
        us_d = us_inc;
        if (tick && us_q == US_W'(TRIG_US - 1)) begin
          state_d = WAIT_RISE;
          us_d    = '0;
        end
      end
      WAIT_RISE: begin
        us_d = us_inc;
        if (rise) begin
          state_d = MEASURE;
          us_d    = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (tick && us_q == US_W'(TIMEOUT_US - 1)) begin
          state_d   = HOLDOFF;
          us_d      = '0;
          pre_clr   = 1'b1;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          width_d   = US_W'(TIMEOUT_US);
          dist_d    = '0;
        end
      end
      MEASURE: begin
        us_d  = us_inc;
        sub_d = sub_inc;
        cm_d  = cm_inc;
        // The fall cycle's own tick is included so the count covers the whole echo window
        if (fall) begin
          state_d   = HOLDOFF;
          us_d      = '0;
          pre_clr   = 1'b1;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          width_d   = us_inc;
          dist_d    = cm_inc;
        end else if (us_inc >= US_W'(TIMEOUT_US)) begin
          state_d   = HOLDOFF;
          us_d      = '0;
          pre_clr   = 1'b1;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          width_d   = US_W'(TIMEOUT_US);
          dist_d    = '0;
        end
      end
      HOLDOFF: begin
        us_d = us_inc;
        if (tick && us_q == US_W'(HOLDOFF_US - 1)) begin
          state_d = IDLE;
          us_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_trigger  <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
      o_width_us <= '0;
      o_dist_cm  <= '0;
    end else begin
      o_trigger  <= (state_d == TRIG);
      o_busy     <= (state_d != IDLE);
      o_valid    <= valid_d;
      o_timeout  <= timeout_d;
      o_width_us <= width_d;
      o_dist_cm  <= dist_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_echo_range_meter.sv
// Scoreboard bench for echo_range_meter at CLKS_PER_US=4, HOLDOFF_US=100, TIMEOUT_US=1000.
module tb_echo_range_meter;

  localparam int unsigned CPU  = 4;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned HOLD = 100;

  typedef struct packed {
    logic        to;
    logic [15:0] w;
    logic [9:0]  d;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        enable = 1'b0;
  logic        echo = 1'b0;
  logic        trigger, busy, valid, timeout;
  logic [15:0] width_us;
  logic [9:0]  dist_cm;
  logic [2:0]  state;

  res_t exp_q[$];
  res_t mon_e;
  int   total = 0;
  int   bad = 0;

  echo_range_meter #(
    .CLKS_PER_US(CPU), .TRIG_US(10), .TIMEOUT_US(TMO), .HOLDOFF_US(HOLD), .US_PER_CM(58)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_enable(enable), .i_echo(echo),
    .o_trigger(trigger), .o_busy(busy), .o_valid(valid), .o_timeout(timeout),
    .o_width_us(width_us), .o_dist_cm(dist_cm), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop one expected result per published strobe
  always @(negedge clk) begin
    if (!rst && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("res_timeout", 32'(timeout), 32'(mon_e.to));
        check_eq("res_width", 32'(width_us), 32'(mon_e.w));
        check_eq("res_dist", 32'(dist_cm), 32'(mon_e.d));
      end
    end
  end

  task automatic push(input logic to, input int w, input int d);
    res_t r;
    r.to = to;
    r.w  = 16'(w);
    r.d  = 10'(d);
    exp_q.push_back(r);
  endtask

  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(valid), 32'd1);
  endtask

  task automatic count_holdoff(input string tag);
    int h = 0;
    while (state === 3'd4 && h < 1000) begin
      h++;
      @(negedge clk);
    end
    check_eq(tag, 32'(h), 32'(HOLD * CPU));
    check_eq({tag, "_idle"}, 32'(state), 32'd0);
  endtask

  task automatic echo_pulse(input int us);
    echo = 1'b1;
    repeat (us * CPU) @(negedge clk);
    echo = 1'b0;
  endtask

  initial begin
    int n;
    int q;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_trig", 32'(trigger), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_width", 32'(width_us), 32'd0);
    check_eq("rst_dist", 32'(dist_cm), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Trigger width and 580 us echo
    kick();
    check_eq("trig_state", 32'(state), 32'd1);
    check_eq("trig_busy", 32'(busy), 32'd1);
    n = 0;
    while (trigger === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("trig_width", 32'(n), 32'd40);
    check_eq("after_trig_state", 32'(state), 32'd2);
    push(1'b0, 580, 10);
    echo_pulse(580);
    wait_valid("meas580_valid", 20, n);
    check_eq("meas580_latency", 32'(n <= 4), 32'd1);
    check_eq("meas580_holdoff_state", 32'(state), 32'd4);
    count_holdoff("meas580_holdoff");
    check_eq("hold_width", 32'(width_us), 32'd580);
    check_eq("hold_dist", 32'(dist_cm), 32'd10);

    // No echo at all
    kick();
    wait_state("noecho_wait", 3'd2, 100);
    push(1'b1, TMO, 0);
    wait_valid("noecho_valid", 5000, n);
    check_eq("noecho_time", 32'(n), 32'(TMO * CPU));
    count_holdoff("noecho_holdoff");

    // Echo rises during the trigger pulse and stays high
    kick();
    echo = 1'b1;
    wait_state("stuck_wait", 3'd2, 100);
    push(1'b1, TMO, 0);
    wait_valid("stuck_valid", 5000, n);
    check_eq("stuck_time", 32'(n), 32'(TMO * CPU));
    count_holdoff("stuck_holdoff");
    echo = 1'b0;
    repeat (5) @(negedge clk);

    // Reset on trigger cycle 20
    kick();
    repeat (19) @(negedge clk);
    check_eq("rst_mid_trig_before", 32'(trigger), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_trig", 32'(trigger), 32'd0);
    check_eq("rst_mid_state", 32'(state), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("rst_mid_idle", 32'(state), 32'd0);
    check_eq("rst_mid_no_pending", 32'(exp_q.size()), 32'd0);

    // Free-running with enable; stray start while busy is not queued
    enable = 1'b1;
    wait_state("en1_wait", 3'd2, 100);
    push(1'b0, 116, 2);
    echo_pulse(116);
    wait_valid("en1_valid", 20, n);
    n = 0;
    while (trigger !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("en_gap", 32'(n), 32'(HOLD * CPU + 1));
    wait_state("en2_wait", 3'd2, 100);
    push(1'b0, 300, 5);
    echo = 1'b1;
    repeat (600) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300 * CPU - 601) @(negedge clk);
    echo = 1'b0;
    wait_valid("en2_valid", 20, n);
    enable = 1'b0;
    wait_state("en_end_idle", 3'd0, 600);
    q = 0;
    repeat (60) begin
      @(negedge clk);
      if (state !== 3'd0) q++;
    end
    check_eq("start_not_queued", 32'(q), 32'd0);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/echo_range_meter.md
ECHO_RANGE_METER -- requirements
Module: echo_range_meter

Interface
Parameters:
REQ-001 The block SHALL have parameter CLKS_PER_US, default 64, meaning i_clk cycles per microsecond (64 MHz sensor clock).
REQ-002 The block SHALL have parameter TRIG_US, default 10, meaning trigger pulse width in µs.
REQ-003 The block SHALL have parameter TIMEOUT_US, default 38000, meaning max wait/echo width in µs before declaring no-target.
REQ-004 The block SHALL have parameter HOLDOFF_US, default 60000, meaning minimum quiet time after each measurement in µs.
REQ-005 The block SHALL have parameter US_PER_CM, default 58, meaning echo µs per cm of range.
Ports (name  direction  width  meaning):
REQ-006 The block SHALL have port i_clk  input  1  sensor-domain clock.
REQ-007 The block SHALL have port i_rst  input  1  reset, synchronous, active-high; clock i_clk.
REQ-008 The block SHALL have port i_start  input  1  single-cycle request for one measurement.
REQ-009 The block SHALL have port i_enable  input  1  level; free-running measurements while high.
REQ-010 The block SHALL have port i_echo  input  1  raw asynchronous HC-SR04 echo pin.
REQ-011 The block SHALL have port o_trigger  output  1  HC-SR04 trigger pin.
REQ-012 The block SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-013 The block SHALL have port o_valid  output  1  one-cycle strobe when a new result is published.
REQ-014 The block SHALL have port o_timeout  output  1  published result is a no-echo/over-range result.
REQ-015 The block SHALL have port o_width_us  output  16  published echo width in µs.
REQ-016 The block SHALL have port o_dist_cm  output  10  published range in cm.
REQ-017 The block SHALL have port o_state  output  3  current FSM state encoding, for bus readback.

Function
REQ-018 i_echo SHALL pass through a 2-flop synchronizer; rise/fall SHALL be detected on the synchronized signal versus its previous value.
REQ-019 A µs prescaler SHALL count 0..CLKS_PER_US-1, clear on entry to TRIG, and emit a one-cycle tick at terminal count.
REQ-020 FSM states/encodings SHALL be IDLE=0, TRIG=1, WAIT_RISE=2, MEASURE=3, HOLDOFF=4.
REQ-021 IDLE -> TRIG when i_start or i_enable is high; the µs counter, cm sub-counter and cm counter SHALL clear on this transition.
REQ-022 TRIG SHALL drive o_trigger high for exactly TRIG_US*CLKS_PER_US cycles, then -> WAIT_RISE; o_trigger SHALL be low in all other states.
REQ-023 WAIT_RISE -> MEASURE on synchronized echo rise (µs counter cleared); -> timeout publish after TIMEOUT_US ticks without rise.
REQ-024 MEASURE SHALL increment the µs counter per tick, and a cm sub-counter per tick that wraps at US_PER_CM-1 and increments the cm counter on wrap.
REQ-025 MEASURE -> publish on synchronized echo fall; -> timeout publish when the µs counter reaches TIMEOUT_US.
REQ-026 Publish SHALL occur on the cycle after the terminating event: o_valid=1 for one cycle; o_width_us/o_dist_cm load the counters; o_timeout loads 1 for timeout, else 0; state -> HOLDOFF.
REQ-027 On timeout, o_width_us SHALL be TIMEOUT_US and o_dist_cm SHALL be 0.
REQ-028 Counters SHALL saturate at all-ones, never wrap.
REQ-029 HOLDOFF SHALL last HOLDOFF_US ticks, then -> IDLE; holdoff SHALL NOT be skipped.
REQ-030 i_start SHALL be ignored while o_busy; a start is not queued.
REQ-031 An echo rise while in TRIG, or an echo still high on entry to WAIT_RISE, SHALL NOT start a measurement; only a fresh rise edge counts.
REQ-032 o_width_us, o_dist_cm and o_timeout SHALL hold until the next publish.
REQ-033 Latency from raw echo fall to o_valid SHALL be at most 4 i_clk cycles.

Reset
REQ-034 While i_rst is high at a clock edge, the state SHALL go to IDLE, with o_trigger=0, o_valid=0, o_timeout=0, o_width_us=0, o_dist_cm=0, o_busy=0, o_state=0, and the synchronizer and counters cleared.
REQ-035 Reset mid-operation, including during TRIG, SHALL drop o_trigger on the next edge, and no o_valid SHALL follow.

Verification (CLKS_PER_US=4, HOLDOFF_US=100, TIMEOUT_US=1000)
REQ-036 Scenario: i_start pulse -> o_trigger high exactly 40 cycles; o_busy=1, o_state=1 during the pulse.
REQ-037 Scenario: echo high 580 µs -> one o_valid, o_width_us=580 (±1), o_dist_cm=10, o_timeout=0.
REQ-038 Scenario: no echo -> o_valid after 1000 µs in WAIT_RISE, o_timeout=1, o_width_us=1000, o_dist_cm=0.
REQ-039 Scenario: echo stuck high -> timeout publish at 1000 µs, then HOLDOFF 100 µs, then IDLE.
REQ-040 Scenario: i_enable held high -> back-to-back measurements separated by ≥100 µs holdoff; i_start during busy is ignored.
REQ-041 Scenario: i_rst asserted on TRIG cycle 20 -> o_trigger=0 next cycle, state IDLE, no o_valid.
